// File: rtl/alu_dispatch.sv
// alu_dispatch: issues one ALU op to the r0 multiplexer, holds it stable,
// ignores stale ready for SETTLE cycles, waits up to TIMEOUT, strobes result.
// Ports: clk, reset_n (async low); decoder op_valid/op_ready/opcode/operand_a/b;
// mux_en/state/value1/value2 out, mux_output1/2/ready in; result_valid/hi/lo/
// wide, timeout_err, busy. Optional `ALU_DISPATCH_FLAGS_EN adds flag_z/flag_n.
module alu_dispatch #(
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] opcode,
  input  logic [7:0] operand_a,
  input  logic [7:0] operand_b,
  output logic       mux_en,
  output logic [1:0] mux_state,
  output logic [7:0] mux_value1,
  output logic [7:0] mux_value2,
  input  logic [7:0] mux_output1,
  input  logic [7:0] mux_output2,
  input  logic       mux_ready,
  output logic       result_valid,
  output logic [7:0] result_hi,
  output logic [7:0] result_lo,
  output logic       result_wide,
  output logic       timeout_err,
  output logic       busy
`ifdef ALU_DISPATCH_FLAGS_EN
  ,
  output logic       flag_z,
  output logic       flag_n
`endif
);

  typedef enum logic [1:0] {
    IDLE, SETTLE_S, WAIT_S, DONE_S
  } state_t;

  localparam logic [7:0] SETTLE_C  = 8'(SETTLE);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [1:0] OP_MUL    = 2'd2;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       en_q;
  logic [1:0] st_q;
  logic [7:0] v1_q;
  logic [7:0] v2_q;
  logic       rv_q;
  logic [7:0] hi_q;
  logic [7:0] lo_q;
  logic       wide_q;
  logic       terr_q;
  logic       fz_q;
  logic       fn_q;
  logic       is_mul;

  assign cnt_d  = cnt_q + 8'd1;
  assign is_mul = (st_q == OP_MUL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      st_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      rv_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      wide_q  <= 1'b0;
      terr_q  <= 1'b0;
      fz_q    <= 1'b0;
      fn_q    <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (op_valid) begin
            st_q    <= opcode;
            v1_q    <= operand_a;
            v2_q    <= operand_b;
            en_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= SETTLE_S;
          end
        end
        SETTLE_S: begin
          cnt_q <= cnt_d;
          if (cnt_d == SETTLE_C) state_q <= WAIT_S;
        end
        WAIT_S: begin
          cnt_q <= cnt_d;
          // ready takes priority over a timeout landing on the same edge
          if (mux_ready) begin
            hi_q    <= is_mul ? mux_output1 : 8'd0;
            lo_q    <= is_mul ? mux_output2 : mux_output1;
            wide_q  <= is_mul;
            terr_q  <= 1'b0;
            fz_q    <= is_mul ? ({mux_output1, mux_output2} == 16'd0)
                              : (mux_output1 == 8'd0);
            // sign is bit 7 of Output1 for both MUL (hi) and others (lo)
            fn_q    <= mux_output1[7];
            en_q    <= 1'b0;
            rv_q    <= 1'b1;
            state_q <= DONE_S;
          end else if (cnt_d == TIMEOUT_C) begin
            hi_q    <= '0;
            lo_q    <= '0;
            wide_q  <= 1'b0;
            terr_q  <= 1'b1;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
            en_q    <= 1'b0;
            rv_q    <= 1'b1;
            state_q <= DONE_S;
          end
        end
        DONE_S: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready     = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign mux_en       = en_q;
  assign mux_state    = st_q;
  assign mux_value1   = v1_q;
  assign mux_value2   = v2_q;
  assign result_valid = rv_q;
  assign result_hi    = hi_q;
  assign result_lo    = lo_q;
  assign result_wide  = wide_q;
  assign timeout_err  = terr_q;

`ifdef ALU_DISPATCH_FLAGS_EN
  assign flag_z = fz_q;
  assign flag_n = fn_q;
`else
  logic unused_flags;
  assign unused_flags = fz_q ^ fn_q;
`endif

endmodule
